vga_rx_decoder: RTL
===================

VGA_RX_DECODER -- requirements
Module: vga_rx_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning pclk periods per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-003 SHALL have parameter H_PIX, default 640, meaning active pixels per line.
REQ-004 SHALL have parameter V_PIX, default 480, meaning active lines per frame.
REQ-005 SHALL have port pclk  in  1  pixel clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port hsync  in  1  horizontal sync, active-low pulse.
REQ-008 SHALL have port vsync  in  1  vertical sync, active-low pulse.
REQ-009 SHALL have port valid  in  1  data enable, high during active pixels.
REQ-010 SHALL have port vga_data  in  24  {r[23:16], g[15:8], b[7:0]}.
REQ-011 SHALL have port pix_we  out  1  framebuffer write strobe.
REQ-012 SHALL have port pix_addr  out  19  v_addr*H_PIX+h_addr.
REQ-013 SHALL have port pix_data  out  24  registered copy of vga_data.
REQ-014 SHALL have port h_addr  out  10  column of the written pixel.
REQ-015 SHALL have port v_addr  out  10  row of the written pixel.
REQ-016 SHALL have port locked  out  1  timing verified, writes enabled.
REQ-017 SHALL have port frame_start  out  1  one-cycle pulse per vsync falling edge.
REQ-018 SHALL have port err  out  1  sticky timing-error flag; cleared only by reset.

Function
REQ-019 SHALL register hsync, vsync and valid each cycle; a falling/rising edge is the current input versus the registered value.
REQ-020 SHALL keep line_cnt: set to 1 on the hsync-fall cycle, else +1, saturating at 1023.
REQ-021 SHALL keep vline_cnt: +1 on each hsync fall; set to 1 when the hsync fall coincides with a vsync fall.
REQ-022 SHALL keep a pixel counter: +1 on each cycle valid=1, cleared on the valid-fall cycle; plus an active-line counter: +1 on each valid fall, cleared on vsync fall.
REQ-023 SHALL flag a mismatch on any of: hsync fall with line_cnt!=H_TOTAL (first hsync fall after entering MEASURE excepted); valid fall with pixel count!=H_PIX; vsync fall with vline_cnt!=V_TOTAL or active lines!=V_PIX.
REQ-024 SHALL implement states SEARCH, MEASURE, LOCKED.
REQ-025 SEARCH->MEASURE on vsync fall; clear all counters and the mismatch record.
REQ-026 MEASURE->LOCKED on the next vsync fall if no mismatch was recorded during the frame; otherwise stay in MEASURE, clear the record and restart measuring.
REQ-027 LOCKED->SEARCH on any mismatch in the same cycle; set err.
REQ-028 locked SHALL be 1 exactly while state==LOCKED, registered; it rises the cycle after the qualifying vsync fall.
REQ-029 In LOCKED, a cycle with valid=1 SHALL produce, one cycle later, pix_we=1, pix_data=vga_data, h_addr=pixel count before increment, v_addr=active-line count, pix_addr=v_addr*H_PIX+h_addr.
REQ-030 pix_we SHALL be 0 outside LOCKED and when valid=0; pix_addr/pix_data hold last values when pix_we=0.
REQ-031 A write is not blocked by a mismatch detected on the same edge; the next cycle is blocked.
REQ-032 Simultaneous hsync and vsync falls: line check, frame check and counter reloads SHALL all apply on that edge.
REQ-033 pix_addr SHALL never exceed H_PIX*V_PIX-1 while locked (307199 default); h_addr and v_addr SHALL be computed at 10 bits with no wrap.

Reset
REQ-034 reset=0 SHALL immediately force state=SEARCH, all counters 0, pix_we=0, pix_addr=0, pix_data=0, h_addr=0, v_addr=0, locked=0, frame_start=0, err=0.
REQ-035 After release, the first vsync fall starts MEASURE; reset asserted mid-frame or mid-line discards all progress.

Verification
REQ-036 Reset: hold reset=0 with toggling inputs -> all outputs 0, locked=0.
REQ-037 Clean 800x525 timing (sync low clocks 1-96 / lines 1-2, active clocks 145-784 / lines 36-515) -> locked=1 one cycle after the 2nd vsync fall; next frame gives 307200 pix_we pulses, first pix_addr=0, last=307199, pix_data=input delayed 1 cycle.
REQ-038 Locked, one line shortened to 799 clocks -> err=1, locked=0 the next cycle, no further pix_we; relock after 2 clean vsync falls, err stays 1.
REQ-039 Locked, one valid run of 639 pixels -> mismatch at the valid fall, locked drops; the 639th pixel is still written.
REQ-040 Frame with 524 lines in MEASURE -> stays unlocked; the following clean frame -> locked.
REQ-041 reset pulsed low mid-frame while locked -> outputs 0 immediately; relock requires 2 further vsync falls.

Source files
------------

// File: rtl/vga_rx_decoder.sv
// VGA receive-side timing decoder: measures sync/enable timing, locks after one
// clean frame, and turns the active pixel stream into framebuffer writes.
module vga_rx_decoder #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_PIX   = 640,
  parameter int V_PIX   = 480
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [23:0] vga_data,
  output logic        pix_we,
  output logic [18:0] pix_addr,
  output logic [23:0] pix_data,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        locked,
  output logic        frame_start,
  output logic        err
);

  localparam logic [9:0]  H_TOTAL_C = 10'(H_TOTAL);
  localparam logic [9:0]  V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0]  H_PIX_C   = 10'(H_PIX);
  localparam logic [9:0]  V_PIX_C   = 10'(V_PIX);
  localparam logic [18:0] H_PIX_A   = 19'(H_PIX);
  localparam logic [9:0]  CNT_MAX   = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state, next_state;
  logic        hsync_q, vsync_q, valid_q;
  logic        hs_fall, vs_fall, vd_fall;
  logic [9:0]  line_cnt, vline_cnt, pix_cnt, act_cnt;
  logic        exempt, mm_rec, mm_now;
  logic        enter_measure, meas_open, in_locked, wr;
  logic [18:0] row_base;

  assign hs_fall = hsync_q & ~hsync;
  assign vs_fall = vsync_q & ~vsync;
  assign vd_fall = valid_q & ~valid;

  // Any timing rule broken on this edge; the first line after entering MEASURE
  // starts from a cleared counter, so its length is not judged.
  assign mm_now = (hs_fall && !exempt && line_cnt != H_TOTAL_C)
               || (vd_fall && pix_cnt != H_PIX_C)
               || (vs_fall && (vline_cnt != V_TOTAL_C || act_cnt != V_PIX_C));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) state <= SEARCH;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      SEARCH:  if (vs_fall) next_state = MEASURE;
      MEASURE: if (vs_fall && !(mm_rec || mm_now)) next_state = LOCKED;
      LOCKED:  if (mm_now) next_state = SEARCH;
      default: next_state = SEARCH;
    endcase
  end

  always_comb begin
    enter_measure = 1'b0;
    meas_open     = 1'b0;
    in_locked     = 1'b0;
    case (state)
      SEARCH:  enter_measure = vs_fall;
      MEASURE: meas_open     = 1'b1;
      LOCKED:  in_locked     = 1'b1;
      default: ;
    endcase
  end

  assign locked = in_locked;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      valid_q <= valid;
    end
  end

  // Sync-edge reloads win over the MEASURE-entry clear so a frame that starts
  // on a coincident hsync/vsync fall is measured from its true first line.
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      line_cnt  <= '0;
      vline_cnt <= '0;
      pix_cnt   <= '0;
      act_cnt   <= '0;
      exempt    <= 1'b0;
      mm_rec    <= 1'b0;
    end else begin
      if (hs_fall)                   line_cnt <= 10'd1;
      else if (enter_measure)        line_cnt <= '0;
      else if (line_cnt != CNT_MAX)  line_cnt <= line_cnt + 10'd1;

      if (hs_fall && vs_fall)                      vline_cnt <= 10'd1;
      else if (enter_measure)                      vline_cnt <= '0;
      else if (hs_fall && vline_cnt != CNT_MAX)    vline_cnt <= vline_cnt + 10'd1;

      if (enter_measure || vd_fall)          pix_cnt <= '0;
      else if (valid && pix_cnt != CNT_MAX)  pix_cnt <= pix_cnt + 10'd1;

      if (vs_fall)                             act_cnt <= '0;
      else if (vd_fall && act_cnt != CNT_MAX)  act_cnt <= act_cnt + 10'd1;

      if (enter_measure) exempt <= 1'b1;
      else if (hs_fall)  exempt <= 1'b0;

      if (meas_open && !vs_fall) mm_rec <= mm_rec | mm_now;
      else                       mm_rec <= 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      err         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vs_fall;
      if (in_locked && mm_now) err <= 1'b1;
    end
  end

  // Writes follow the state at this edge, so a mismatch found on the same edge
  // does not cancel the pixel; the bounds keep pix_addr inside the frame.
  assign wr       = in_locked && valid && (pix_cnt < H_PIX_C) && (act_cnt < V_PIX_C);
  assign row_base = {9'd0, act_cnt} * H_PIX_A;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      pix_we   <= 1'b0;
      pix_addr <= '0;
      pix_data <= '0;
      h_addr   <= '0;
      v_addr   <= '0;
    end else begin
      pix_we <= wr;
      if (wr) begin
        pix_addr <= row_base + {9'd0, pix_cnt};
        pix_data <= vga_data;
        h_addr   <= pix_cnt;
        v_addr   <= act_cnt;
      end
    end
  end

endmodule
